// File: rtl/serial_tx.sv
// Parallel-to-serial transmitter: sends a WIDTH-bit word LSB-first framed by a
// start bit (0) and a stop bit (1), holding every bit for CLKS_PER_BIT clocks.
module serial_tx #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load,
    output logic             ready,
    output logic             tx,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             done_q, done_d;

    logic             bit_end;
    logic [WIDTH-1:0] shift_nx;

    assign bit_end  = (cnt_q == CNT_LAST);
    assign shift_nx = shift_q >> 1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (load) begin
                    shift_d = data_in;
                    tx_d    = 1'b0;
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    tx_d    = shift_q[0];
                    state_d = DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
                    // Last data bit finished: stop bit goes out, index rewinds
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        shift_d = shift_nx;
                        tx_d    = shift_nx[0];
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    // All outputs are decoded from registers only; load never reaches them combinationally.
    assign ready = (state_q == IDLE);
    assign busy  = !ready;
    assign tx    = tx_q;
    assign done  = done_q;

endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx: an 8-bit/4-clock instance and a 4-bit/1-clock instance,
// compared against a slot-based frame model.
module tb_serial_tx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic [7:0] data8 = '0;
    logic       load8 = 1'b0;
    logic       ready8, tx8, busy8, done8;

    logic [3:0] data4 = '0;
    logic       load4 = 1'b0;
    logic       ready4, tx4, busy4, done4;

    int n_tests = 0;
    int n_fail  = 0;

    serial_tx #(.WIDTH(8), .CLKS_PER_BIT(4)) dut (
        .clk(clk), .rst_n(rst_n), .data_in(data8), .load(load8),
        .ready(ready8), .tx(tx8), .busy(busy8), .done(done8)
    );

    serial_tx #(.WIDTH(4), .CLKS_PER_BIT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .data_in(data4), .load(load4),
        .ready(ready4), .tx(tx4), .busy(busy4), .done(done4)
    );

    always #5 clk = ~clk;

    // Expected line level t cycles after the accept edge: slot 0 is the start
    // bit, slots 1..w carry d LSB-first, everything after is stop/idle high.
    function automatic logic exp_tx(input logic [7:0] d, input int w, input int c, input int t);
        int slot;
        slot = t / c;
        if (slot == 0) return 1'b0;
        if (slot <= w) return d[slot-1];
        return 1'b1;
    endfunction

    // Leaves the bench at t=0: one time unit after the accept edge.
    task automatic accept8(input logic [7:0] d);
        @(negedge clk);
        data8 = d;
        load8 = 1'b1;
        @(posedge clk);
        #1;
        load8 = 1'b0;
        data8 = 8'($urandom);
    endtask

    task automatic accept4(input logic [3:0] d);
        @(negedge clk);
        data4 = d;
        load4 = 1'b1;
        @(posedge clk);
        #1;
        load4 = 1'b0;
        data4 = 4'($urandom);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if ({tx8, ready8, busy8, done8} !== 4'b1100) begin
            n_fail++;
            $display("FAIL reset_w8 got={tx,ready,busy,done}=%b exp=1100", {tx8, ready8, busy8, done8});
        end
        n_tests++;
        if ({tx4, ready4, busy4, done4} !== 4'b1100) begin
            n_fail++;
            $display("FAIL reset_w4 got={tx,ready,busy,done}=%b exp=1100", {tx4, ready4, busy4, done4});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_idle;
        for (int t = 0; t < 100; t++) begin
            @(posedge clk);
            #1;
            n_tests++;
            if ({tx8, ready8, done8} !== 3'b110) begin
                n_fail++;
                $display("FAIL idle t=%0d got={tx,ready,done}=%b exp=110", t, {tx8, ready8, done8});
            end
        end
    endtask

    task automatic test_frame_a5;
        int busy_cnt = 0;
        int done_cnt = 0;
        int done_at = -1;
        accept8(8'hA5);
        for (int t = 0; t <= 44; t++) begin
            n_tests++;
            if (tx8 !== exp_tx(8'hA5, 8, 4, t)) begin
                n_fail++;
                $display("FAIL frame_a5 t=%0d tx got=%b exp=%b", t, tx8, exp_tx(8'hA5, 8, 4, t));
            end
            if (busy8 === 1'b1) busy_cnt++;
            if (done8 === 1'b1) begin
                done_cnt++;
                done_at = t;
            end
            @(posedge clk);
            #1;
        end
        n_tests++;
        if (busy_cnt != 40) begin
            n_fail++;
            $display("FAIL a5_busy_len got=%0d exp=40", busy_cnt);
        end
        n_tests++;
        if (done_cnt != 1 || done_at != 40) begin
            n_fail++;
            $display("FAIL a5_done got count=%0d at=%0d exp count=1 at=40", done_cnt, done_at);
        end
    endtask

    task automatic test_random_frames;
        for (int f = 0; f < 4; f++) begin
            logic [7:0] d;
            int done_at;
            d = 8'($urandom);
            done_at = -1;
            accept8(d);
            for (int t = 0; t <= 41; t++) begin
                n_tests++;
                if (tx8 !== exp_tx(d, 8, 4, t) || busy8 !== (t < 40)) begin
                    n_fail++;
                    $display("FAIL rand_frame d=%h t=%0d got tx=%b busy=%b exp tx=%b busy=%b",
                             d, t, tx8, busy8, exp_tx(d, 8, 4, t), (t < 40));
                end
                if (done8 === 1'b1) done_at = t;
                @(posedge clk);
                #1;
            end
            n_tests++;
            if (done_at != 40) begin
                n_fail++;
                $display("FAIL rand_done d=%h got at=%0d exp at=40", d, done_at);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic tx_hist [0:81];
        int   done_t [$];
        int   run;
        @(negedge clk);
        data8 = 8'h00;
        load8 = 1'b1;
        @(posedge clk);
        #1;
        data8 = 8'hFF;
        for (int t = 0; t <= 81; t++) begin
            logic e;
            e = (t < 41) ? exp_tx(8'h00, 8, 4, t) : exp_tx(8'hFF, 8, 4, t - 41);
            tx_hist[t] = tx8;
            n_tests++;
            if (tx8 !== e) begin
                n_fail++;
                $display("FAIL b2b t=%0d tx got=%b exp=%b", t, tx8, e);
            end
            if (done8 === 1'b1) done_t.push_back(t);
            if (t == 81) load8 = 1'b0;
            else begin
                @(posedge clk);
                #1;
            end
        end
        run = 0;
        for (int t = 36; t <= 81 && tx_hist[t] === 1'b1; t++) run++;
        n_tests++;
        if (run != 5) begin
            n_fail++;
            $display("FAIL b2b_gap got=%0d exp=5", run);
        end
        n_tests++;
        if (done_t.size() != 2) begin
            n_fail++;
            $display("FAIL b2b_done_count got=%0d exp=2", done_t.size());
        end else begin
            n_tests++;
            if (done_t[1] - done_t[0] != 41 || done_t[0] != 40) begin
                n_fail++;
                $display("FAIL b2b_done_spacing got first=%0d gap=%0d exp first=40 gap=41",
                         done_t[0], done_t[1] - done_t[0]);
            end
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_load_while_busy;
        int done_cnt = 0;
        accept8(8'h3C);
        for (int t = 0; t <= 50; t++) begin
            n_tests++;
            if (tx8 !== exp_tx(8'h3C, 8, 4, t)) begin
                n_fail++;
                $display("FAIL busy_load t=%0d tx got=%b exp=%b", t, tx8, exp_tx(8'h3C, 8, 4, t));
            end
            if (done8 === 1'b1) done_cnt++;
            if (t == 15) begin
                data8 = 8'hC3;
                load8 = 1'b1;
            end else if (t == 16) begin
                load8 = 1'b0;
            end else begin
                data8 = 8'($urandom);
            end
            @(posedge clk);
            #1;
        end
        n_tests++;
        if (done_cnt != 1 || ready8 !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_load_end got done_count=%0d ready=%b exp done_count=1 ready=1",
                     done_cnt, ready8);
        end
    endtask

    task automatic test_async_reset;
        int done_at = -1;
        accept8(8'h5A);
        for (int t = 0; t < 13; t++) begin
            @(posedge clk);
            #1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({tx8, ready8, busy8, done8} !== 4'b1100) begin
            n_fail++;
            $display("FAIL async_reset got={tx,ready,busy,done}=%b exp=1100", {tx8, ready8, busy8, done8});
        end
        @(negedge clk);
        rst_n = 1'b1;
        accept8(8'h81);
        for (int t = 0; t <= 41; t++) begin
            n_tests++;
            if (tx8 !== exp_tx(8'h81, 8, 4, t)) begin
                n_fail++;
                $display("FAIL post_reset_frame t=%0d tx got=%b exp=%b", t, tx8, exp_tx(8'h81, 8, 4, t));
            end
            if (done8 === 1'b1) done_at = t;
            @(posedge clk);
            #1;
        end
        n_tests++;
        if (done_at != 40) begin
            n_fail++;
            $display("FAIL post_reset_done got at=%0d exp at=40", done_at);
        end
    endtask

    task automatic test_c1;
        logic [3:0] words [0:3];
        words[0] = 4'b1001;
        for (int i = 1; i < 4; i++) words[i] = 4'($urandom);
        for (int f = 0; f < 4; f++) begin
            accept4(words[f]);
            for (int t = 0; t <= 8; t++) begin
                logic e;
                e = exp_tx({4'b0, words[f]}, 4, 1, t);
                n_tests++;
                if (tx4 !== e || done4 !== (t == 6) || busy4 !== (t < 6)) begin
                    n_fail++;
                    $display("FAIL c1 d=%b t=%0d got tx=%b done=%b busy=%b exp tx=%b done=%b busy=%b",
                             words[f], t, tx4, done4, busy4, e, (t == 6), (t < 6));
                end
                @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_frame_a5();
        test_random_frames();
        test_back_to_back();
        test_load_while_busy();
        test_async_reset();
        test_c1();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
